// File: rtl/multi_channel_seq_pkg.sv
// Shared types for the multi-channel tile sequencer.
// State encoding, error codes and a phase helper.
package multi_channel_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        PROC,
        WRITE,
        NEXT,
        DONE,
        ERR
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_RD   = 2'd1;
    localparam logic [1:0] ERR_PROC = 2'd2;
    localparam logic [1:0] ERR_WR   = 2'd3;

    function automatic logic is_phase(input state_e s);
        return (s == READ) || (s == PROC) || (s == WRITE);
    endfunction

endpackage

// File: rtl/multi_channel_sequencer_phase_watchdog.sv
// Per-phase cycle counter; flags the last allowed cycle of a phase.
// Restarts from zero whenever the phase changes or goes inactive.
module phase_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic active,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = active && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !active) begin
            cnt_d = '0;
        end else if (!expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multi_channel_sequencer.sv
// Tile sequencer: READ -> PROC -> WRITE per tile across NUM_CH channels.
// Registered Moore outputs, per-phase watchdog, channel mask and abort.
module multi_channel_sequencer
    import multi_channel_seq_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int TILE_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              rd_done,
    input  logic              wr_done,
    input  logic [NUM_CH-1:0] finish,
    output logic              rd_en,
    output logic              wr_en,
    output logic [NUM_CH-1:0] enable,
    output logic [TILE_W-1:0] tile_idx,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    state_e            state_q, state_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic [TILE_W-1:0] num_q, num_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] fin_q, fin_d;
    logic [NUM_CH-1:0] fin_all;
    logic [1:0]        code_q, code_d;

    logic              rd_en_q, wr_en_q, busy_q, done_q, error_q;
    logic [NUM_CH-1:0] enable_q, enable_d;

    logic wd_clear, wd_active, wd_exp;

    phase_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .active  (wd_active),
        .expired (wd_exp)
    );

    assign wd_active = is_phase(state_q);
    assign wd_clear  = (state_d != state_q);
    assign fin_all   = (fin_q | finish) & mask_q;

    always_comb begin
        state_d = state_q;
        tile_d  = tile_q;
        num_d   = num_q;
        mask_d  = mask_q;
        fin_d   = fin_q;
        code_d  = code_q;
        if (abort) begin
            state_d = IDLE;
            tile_d  = '0;
            fin_d   = '0;
            code_d  = ERR_NONE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        num_d  = num_tiles;
                        mask_d = ch_mask;
                        if (num_tiles == '0 || ch_mask == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d = READ;
                            tile_d  = '0;
                        end
                    end
                end
                READ: begin
                    if (rd_done) begin
                        state_d = PROC;
                    end else if (wd_exp) begin
                        state_d = ERR;
                        code_d  = ERR_RD;
                    end
                end
                PROC: begin
                    // completion this cycle beats a simultaneous timeout
                    if (fin_all == mask_q) begin
                        state_d = WRITE;
                        fin_d   = '0;
                    end else if (wd_exp) begin
                        state_d = ERR;
                        code_d  = ERR_PROC;
                        fin_d   = '0;
                    end else begin
                        fin_d = fin_all;
                    end
                end
                WRITE: begin
                    if (wr_done) begin
                        state_d = NEXT;
                    end else if (wd_exp) begin
                        state_d = ERR;
                        code_d  = ERR_WR;
                    end
                end
                NEXT: begin
                    if (tile_q == num_q - TILE_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                        tile_d  = tile_q + TILE_W'(1);
                    end
                end
                DONE: state_d = IDLE;
                ERR:  state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    assign enable_d = (state_d == PROC) ? (mask_d & ~fin_d) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            tile_q   <= '0;
            num_q    <= '0;
            mask_q   <= '0;
            fin_q    <= '0;
            code_q   <= ERR_NONE;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            enable_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tile_q   <= tile_d;
            num_q    <= num_d;
            mask_q   <= mask_d;
            fin_q    <= fin_d;
            code_q   <= code_d;
            rd_en_q  <= (state_d == READ);
            wr_en_q  <= (state_d == WRITE);
            enable_q <= enable_d;
            busy_q   <= (state_d == READ) || (state_d == PROC)
                     || (state_d == WRITE) || (state_d == NEXT);
            done_q   <= (state_d == DONE);
            error_q  <= (state_d == ERR);
        end
    end

    assign rd_en    = rd_en_q;
    assign wr_en    = wr_en_q;
    assign enable   = enable_q;
    assign tile_idx = tile_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = code_q;

endmodule

// File: tb/tb_multi_channel_sequencer.sv
// Scoreboarded bench for multi_channel_sequencer.
// Expected read/done/error events are queued with stimulus and popped by a monitor.
module tb_multi_channel_sequencer;

    localparam int NUM_CH  = 4;
    localparam int TILE_W  = 16;
    localparam int TIMEOUT = 32;

    localparam int EV_RD   = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    logic              clk = 1'b0;
    logic              reset, start, abort, rd_done, wr_done;
    logic [TILE_W-1:0] num_tiles;
    logic [NUM_CH-1:0] ch_mask, finish;
    logic              rd_en, wr_en, busy, done, error;
    logic [NUM_CH-1:0] enable;
    logic [TILE_W-1:0] tile_idx;
    logic [1:0]        err_code;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t sb[$];
    int  n_chk = 0;
    int  n_err = 0;
    logic rd_prev = 1'b0;
    logic err_prev = 1'b0;

    multi_channel_sequencer #(
        .NUM_CH  (NUM_CH),
        .TILE_W  (TILE_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .num_tiles (num_tiles),
        .ch_mask   (ch_mask),
        .rd_done   (rd_done),
        .wr_done   (wr_done),
        .finish    (finish),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .enable    (enable),
        .tile_idx  (tile_idx),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic expect_ev(input int k, input int v);
        ev_t e;
        if (sb.size() == 0) begin
            chk("sb_unexpected_event", 32'(k), 32'hFFFF_FFFF);
        end else begin
            e = sb.pop_front();
            chk("sb_kind", 32'(k), 32'(e.kind));
            chk("sb_val", 32'(v), 32'(e.val));
        end
    endtask

    task automatic push(input int k, input int v);
        sb.push_back('{k, v});
    endtask

    always @(negedge clk) begin
        if (rd_en === 1'b1 && rd_prev === 1'b0) expect_ev(EV_RD, int'(tile_idx));
        if (done === 1'b1) expect_ev(EV_DONE, 0);
        if (error === 1'b1 && err_prev === 1'b0) expect_ev(EV_ERR, int'(err_code));
        rd_prev  <= rd_en;
        err_prev <= error;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n, input logic [NUM_CH-1:0] m);
        num_tiles = TILE_W'(n);
        ch_mask   = m;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic pulse_rd();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
    endtask

    task automatic pulse_wr();
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
    endtask

    task automatic pulse_fin(input logic [NUM_CH-1:0] f);
        finish = f;
        tick();
        finish = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int k;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        rd_done = 1'b0;
        wr_done = 1'b0;
        finish = '0;
        num_tiles = '0;
        ch_mask = '0;
        repeat (3) tick();
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_enable", enable, 0);
        chk("rst_tile", tile_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_code", err_code, 0);
        reset = 1'b0;
        tick();

        // three full tiles, all channels, staggered finishes
        for (int t = 0; t < 3; t++) push(EV_RD, t);
        push(EV_DONE, 0);
        start_run(3, 4'hF);
        for (int t = 0; t < 3; t++) begin
            chk("t1_rd_en", rd_en, 1);
            chk("t1_tile", tile_idx, t);
            chk("t1_busy", busy, 1);
            repeat (4) tick();
            pulse_rd();
            chk("t1_rd_drop", rd_en, 0);
            chk("t1_en_all", enable, 4'hF);
            pulse_fin(4'b0001);
            chk("t1_en_a", enable, 4'b1110);
            tick();
            pulse_fin(4'b0100);
            chk("t1_en_b", enable, 4'b1010);
            pulse_fin(4'b0010);
            chk("t1_en_c", enable, 4'b1000);
            chk("t1_no_wr", wr_en, 0);
            tick();
            pulse_fin(4'b1000);
            chk("t1_wr_en", wr_en, 1);
            chk("t1_en_off", enable, 0);
            repeat (4) tick();
            pulse_wr();
            chk("t1_wr_drop", wr_en, 0);
            chk("t1_next_busy", busy, 1);
            tick();
        end
        chk("t1_done", done, 1);
        chk("t1_done_busy", busy, 0);
        tick();
        chk("t1_done_width", done, 0);
        chk("t1_tile_hold", tile_idx, 2);
        chk("t1_no_error", error, 0);

        // masked channels never finish -> process timeout
        push(EV_RD, 0);
        push(EV_ERR, 2);
        start_run(1, 4'b0101);
        pulse_rd();
        k = 0;
        pulse_fin(4'b1010);
        k++;
        chk("t2_en_masked", enable, 4'b0101);
        while (!error && k < TIMEOUT + 8) begin
            tick();
            k++;
        end
        chk("t2_proc_lat", k, TIMEOUT);
        chk("t2_code", err_code, 2);
        chk("t2_en_err", enable, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t2_abort_err", error, 0);
        chk("t2_abort_code", err_code, 0);

        // simultaneous finishes on both active channels
        push(EV_RD, 0);
        push(EV_DONE, 0);
        start_run(1, 4'b0101);
        pulse_rd();
        pulse_fin(4'b0101);
        chk("t2_simul_wr", wr_en, 1);
        pulse_wr();
        tick();
        chk("t2_done", done, 1);
        tick();

        // no rd_done -> read timeout
        push(EV_RD, 0);
        push(EV_ERR, 1);
        start_run(1, 4'hF);
        chk("t3_rd_en", rd_en, 1);
        k = 0;
        while (!error && k < TIMEOUT + 8) begin
            tick();
            k++;
        end
        chk("t3_rd_lat", k, TIMEOUT);
        chk("t3_code", err_code, 1);
        chk("t3_rd_off", rd_en, 0);
        start_run(1, 4'hF);
        chk("t3_start_ign", error, 1);
        chk("t3_start_rd", rd_en, 0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_abort_err", error, 0);
        chk("t3_abort_busy", busy, 0);

        // empty runs complete immediately
        push(EV_DONE, 0);
        start_run(0, 4'hF);
        chk("t4_done", done, 1);
        chk("t4_no_rd", rd_en, 0);
        tick();
        chk("t4_done_end", done, 0);
        push(EV_DONE, 0);
        start_run(2, 4'h0);
        chk("t4_mask0_done", done, 1);
        tick();

        // abort beats wr_done in WRITE
        push(EV_RD, 0);
        start_run(2, 4'b0001);
        pulse_rd();
        pulse_fin(4'b0001);
        chk("t5_wr_en", wr_en, 1);
        wr_done = 1'b1;
        abort = 1'b1;
        tick();
        wr_done = 1'b0;
        abort = 1'b0;
        chk("t5_wr_off", wr_en, 0);
        chk("t5_busy", busy, 0);
        chk("t5_no_done", done, 0);
        repeat (3) tick();
        chk("t5_idle_rd", rd_en, 0);

        // reset in PROC of tile 1, then a fresh run
        push(EV_RD, 0);
        push(EV_RD, 1);
        start_run(2, 4'hF);
        pulse_rd();
        pulse_fin(4'hF);
        pulse_wr();
        tick();
        pulse_rd();
        chk("t6_en_t1", enable, 4'hF);
        chk("t6_tile1", tile_idx, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_en", enable, 0);
        chk("t6_rst_tile", tile_idx, 0);
        chk("t6_rst_busy", busy, 0);
        push(EV_RD, 0);
        push(EV_DONE, 0);
        start_run(1, 4'b0011);
        chk("t6_new_tile", tile_idx, 0);
        pulse_rd();
        pulse_fin(4'b0011);
        pulse_wr();
        tick();
        chk("t6_done", done, 1);
        repeat (2) tick();

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
